pool2d_stream: RTL

POOL2D_STREAM -- requirements
Module: pool2d_stream

---
 rtl/pool2d_stream.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pool2d_stream.sv
// Streaming 2-D max/average/min pooling over a raster pixel stream.
// Uses one horizontal accumulator plus one row of partial window results.
module pool2d_stream #(
   parameter int DATA_WIDTH = 22,
   parameter int IMG_W      = 30,
   parameter int IMG_H      = 30,
   parameter int POOL_K     = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [1:0]                   pool_type,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] pixel_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] result_out,
   output logic                         done
);

   localparam int LOG2K = (POOL_K == 4) ? 2 : 1;
   localparam int SHIFT = 2 * LOG2K;
   localparam int SUM_W = DATA_WIDTH + SHIFT;
   localparam int W_OUT = IMG_W / POOL_K;
   localparam int H_OUT = IMG_H / POOL_K;
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int OX_W  = (W_OUT > 1) ? $clog2(W_OUT) : 1;

   generate
      if (POOL_K != 2 && POOL_K != 4) begin : g_bad_pool_k
         $error("pool2d_stream: POOL_K must be 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                    state, next_state;
   logic [COL_W-1:0]          col;
   logic [ROW_W-1:0]          row;
   logic [1:0]                mode;
   logic signed [SUM_W-1:0]   h_acc;
   logic signed [SUM_W-1:0]   col_buf [0:W_OUT-1];

   logic                      accept;
   logic                      last_pixel;
   logic                      in_window;
   logic [LOG2K-1:0]          kx, ky;
   logic [OX_W-1:0]           ox;
   logic signed [SUM_W-1:0]   pix_ext;
   logic signed [SUM_W-1:0]   h_val;
   logic signed [SUM_W-1:0]   v_val;
   logic signed [DATA_WIDTH-1:0] pooled;
   logic                      load_result;

   function automatic logic signed [SUM_W-1:0] combine(
      input logic signed [SUM_W-1:0] a,
      input logic signed [SUM_W-1:0] b,
      input logic [1:0]              m
   );
      logic signed [SUM_W-1:0] r;
      r = (a > b) ? a : b;
      case (m)
         2'b01:   r = a + b;
         2'b10:   r = (a < b) ? a : b;
         default: r = (a > b) ? a : b;
      endcase
      return r;
   endfunction

   assign in_ready   = (state == S_RUN) && (!out_valid || out_ready);
   assign done       = (state == S_DONE);
   assign accept     = in_valid && in_ready;
   assign last_pixel = (int'(col) == IMG_W - 1) && (int'(row) == IMG_H - 1);
   assign in_window  = (int'(col) < W_OUT * POOL_K) && (int'(row) < H_OUT * POOL_K);
   assign kx         = col[LOG2K-1:0];
   assign ky         = row[LOG2K-1:0];
   assign ox         = OX_W'(col >> LOG2K);
   assign pix_ext    = {{SHIFT{pixel_in[DATA_WIDTH-1]}}, pixel_in};

   // Fold the pixel into the horizontal run, then into the column's partial result
   // from the rows above; the first row/column of a window starts fresh.
   always_comb begin
      h_val       = (kx == '0) ? pix_ext : combine(h_acc, pix_ext, mode);
      v_val       = (ky == '0) ? h_val : combine(col_buf[ox], h_val, mode);
      pooled      = (mode == 2'b01) ? DATA_WIDTH'(v_val >>> SHIFT) : DATA_WIDTH'(v_val);
      load_result = accept && in_window && (&kx) && (&ky);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start) next_state = S_RUN;
         S_RUN:   if (accept && last_pixel) next_state = S_DRAIN;
         S_DRAIN: if (!out_valid || out_ready) next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Counters and partial sums; pixels outside the pooled area only move the counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col   <= '0;
         row   <= '0;
         mode  <= '0;
         h_acc <= '0;
         for (int i = 0; i < W_OUT; i++) begin
            col_buf[i] <= '0;
         end
      end else if (state == S_IDLE && start) begin
         col  <= '0;
         row  <= '0;
         mode <= pool_type;
      end else if (accept) begin
         if (int'(col) == IMG_W - 1) begin
            col <= '0;
            row <= (int'(row) == IMG_H - 1) ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
         if (in_window) begin
            h_acc <= h_val;
            if (&kx) begin
               col_buf[ox] <= v_val;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         result_out <= '0;
      end else if (load_result) begin
         out_valid  <= 1'b1;
         result_out <= pooled;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
